serial_demux_sequencer: RTL and testbench

SERIAL_DEMUX_SEQUENCER -- requirements
Module: serial_demux_sequencer

---
 rtl/serial_demux_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_serial_demux_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_demux_sequencer.sv
// serial_demux_sequencer: step-driven serial frame receiver.
// Frame: start bit, 2-bit port (MSB first), CNT_W-bit length (MSB first),
// then `length` data bits routed to p0..p3 according to the port field.
// Optional feature macro: SERDEMUX_PARITY_EN adds a trailing even-parity bit
// and a sticky err flag; without it err is tied low.
`timescale 1ns/1ps

module serial_demux_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             ser_in,
  output logic [1:0]       port_num,
  output logic             p0,
  output logic             p1,
  output logic             p2,
  output logic             p3,
  output logic             ser_out_valid,
  output logic [CNT_W-1:0] d_cnt,
  output logic             done,
  output logic             err
);

  localparam int unsigned    BIT_W    = $clog2(CNT_W + 2);
  localparam logic [BIT_W-1:0] PORT_LAST = BIT_W'(1);
  localparam logic [BIT_W-1:0] LEN_LAST  = BIT_W'(CNT_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
`ifdef SERDEMUX_PARITY_EN
    ,
    PAR  = 3'd5
`endif
  } state_t;

  // State entered once the data phase (or a zero-length header) completes
`ifdef SERDEMUX_PARITY_EN
  localparam state_t AFTER_DATA = PAR;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t             state_q, state_d;
  logic [1:0]         port_q, port_d;
  logic [3:0]         p_q, p_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
`ifdef SERDEMUX_PARITY_EN
  logic               par_q, par_d;
  logic               err_q, err_d;
`endif

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bit_q   <= '0;
`ifdef SERDEMUX_PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
`ifdef SERDEMUX_PARITY_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs become visible one clk later
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    p_d     = p_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bit_d   = bit_q;
`ifdef SERDEMUX_PARITY_EN
    par_d   = par_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (clk_en && ser_in) begin
          state_d = PORT;
          port_d  = '0;
          cnt_d   = '0;
          p_d     = '0;
          bit_d   = '0;
`ifdef SERDEMUX_PARITY_EN
          par_d   = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      PORT: begin
        if (clk_en) begin
          port_d = {port_q[0], ser_in};
          if (bit_q == PORT_LAST) begin
            bit_d   = '0;
            state_d = LEN;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      LEN: begin
        if (clk_en) begin
          cnt_d = CNT_W'({cnt_q, ser_in});
          if (bit_q == LEN_LAST) begin
            bit_d   = '0;
            state_d = (cnt_d != '0) ? DATA : AFTER_DATA;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      DATA: begin
        if (clk_en) begin
          p_d[port_q] = ser_in;
          valid_d     = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
`ifdef SERDEMUX_PARITY_EN
          par_d       = par_q ^ ser_in;
`endif
          if (cnt_q == CNT_W'(1)) begin
            state_d = AFTER_DATA;
          end
        end
      end
`ifdef SERDEMUX_PARITY_EN
      PAR: begin
        if (clk_en) begin
          err_d   = par_q ^ ser_in;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // done is high for exactly the single cycle spent in DONE
    done_d = (state_d == DONE);
  end

  assign port_num      = port_q;
  assign p0            = p_q[0];
  assign p1            = p_q[1];
  assign p2            = p_q[2];
  assign p3            = p_q[3];
  assign ser_out_valid = valid_q;
  assign d_cnt         = cnt_q;
  assign done          = done_q;
`ifdef SERDEMUX_PARITY_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_serial_demux_sequencer.sv
// Directed bench for serial_demux_sequencer (CNT_W = 4).
// Builds with or without SERDEMUX_PARITY_EN; parity steps are added when set.
`timescale 1ns/1ps

module tb_serial_demux_sequencer;

  localparam int unsigned CNT_W = 4;
`ifdef SERDEMUX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             clk_en;
  logic             ser_in;
  logic [1:0]       port_num;
  logic             p0, p1, p2, p3;
  logic             ser_out_valid;
  logic [CNT_W-1:0] d_cnt;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  serial_demux_sequencer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .ser_in        (ser_in),
    .port_num      (port_num),
    .p0            (p0),
    .p1            (p1),
    .p2            (p2),
    .p3            (p3),
    .ser_out_valid (ser_out_valid),
    .d_cnt         (d_cnt),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_port, input logic [3:0] e_p,
                            input logic e_valid, input logic [CNT_W-1:0] e_cnt,
                            input logic e_done, input logic e_err);
    check({tag, ".port_num"}, 32'(port_num), 32'(e_port));
    check({tag, ".p"}, 32'({p3, p2, p1, p0}), 32'(e_p));
    check({tag, ".valid"}, 32'(ser_out_valid), 32'(e_valid));
    check({tag, ".d_cnt"}, 32'(d_cnt), 32'(e_cnt));
    check({tag, ".done"}, 32'(done), 32'(e_done));
    check({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  // One clk_en cycle with ser_in=b; returns on the negedge after the sampling edge
  task automatic step(input logic b);
    @(negedge clk);
    clk_en = 1'b1;
    ser_in = b;
    @(negedge clk);
    clk_en = 1'b0;
    ser_in = 1'b0;
  endtask

  task automatic steps(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i]);
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    ser_in = 1'b0;
    #3 rst = 1'b0;
    #1;
    check_outs("reset", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Port 2, length 3, data 1,0,1
    step(1'b1);
    check_outs("a_start", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    steps(16'b10, 2);
    check("a_port", 32'(port_num), 32'd2);
    steps(16'b0011, 4);
    check_outs("a_len", 2'd2, 4'b0000, 1'b0, 4'd3, 1'b0, 1'b0);
    step(1'b1);
    check_outs("a_d0", 2'd2, 4'b0100, 1'b1, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("a_d0_gap", 2'd2, 4'b0100, 1'b0, 4'd2, 1'b0, 1'b0);
    step(1'b0);
    check_outs("a_d1", 2'd2, 4'b0000, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1);
    check_outs("a_d2", 2'd2, 4'b0100, 1'b1, 4'd0, ~PAR_EN, 1'b0);
`ifdef SERDEMUX_PARITY_EN
    step(1'b1);
    check_outs("a_par1", 2'd2, 4'b0100, 1'b0, 4'd0, 1'b1, 1'b1);
`endif
    @(negedge clk);
    check_outs("a_after", 2'd2, 4'b0100, 1'b0, 4'd0, 1'b0, PAR_EN);
    step(1'b0);
    check_outs("a_idle_zero", 2'd2, 4'b0100, 1'b0, 4'd0, 1'b0, PAR_EN);

    // Port 1, length 0: no strobes, single done
    step(1'b1);
    check_outs("b_start", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    steps(16'b01, 2);
    steps(16'b0000, 4);
`ifdef SERDEMUX_PARITY_EN
    check("b_no_done_before_par", 32'(done), 32'd0);
    step(1'b0);
`endif
    check_outs("b_done", 2'd1, 4'b0000, 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("b_after", 2'd1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);

`ifdef SERDEMUX_PARITY_EN
    // Same frame as above with parity 0: even parity holds, err stays low
    step(1'b1);
    steps(16'b10, 2);
    steps(16'b0011, 4);
    steps(16'b101, 3);
    step(1'b0);
    check_outs("d_par0", 2'd2, 4'b0100, 1'b0, 4'd0, 1'b1, 1'b0);
`endif

    // Port 3, length 15, with a 20-cycle clk_en gap in the middle of LEN
    step(1'b1);
    steps(16'b11, 2);
    steps(16'b11, 2);
    check_outs("c_len_half", 2'd3, 4'b0000, 1'b0, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ser_in = i[0];
    end
    @(negedge clk);
    ser_in = 1'b0;
    check_outs("c_len_hold", 2'd3, 4'b0000, 1'b0, 4'd3, 1'b0, 1'b0);
    steps(16'b11, 2);
    check_outs("c_len_full", 2'd3, 4'b0000, 1'b0, 4'd15, 1'b0, 1'b0);
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      logic b;
      b = (i % 2 == 0);
      step(b);
      if (ser_out_valid === 1'b1) strobes++;
      check("c_p3", 32'({p3, p2, p1, p0}), 32'({b, 3'b000}));
      check("c_cnt", 32'(d_cnt), 32'(14 - i));
    end
    check("c_strobes", 32'(strobes), 32'd15);
`ifdef SERDEMUX_PARITY_EN
    step(1'b0);
`endif
    check_outs("c_done", 2'd3, 4'b1000, ~PAR_EN, 4'd0, 1'b1, 1'b0);
    // clk_en with a start-like bit during DONE must be ignored
    clk_en = 1'b1;
    ser_in = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    ser_in = 1'b0;
    check_outs("c_done_ignored", 2'd3, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
    // Back-to-back start on the first clk_en after done
    step(1'b1);
    check_outs("c_b2b_start", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    steps(16'b00, 2);
    steps(16'b0000, 4);
`ifdef SERDEMUX_PARITY_EN
    step(1'b0);
`endif
    check("c_b2b_done", 32'(done), 32'd1);

    // Asynchronous reset in the middle of DATA
    step(1'b1);
    steps(16'b10, 2);
    steps(16'b0011, 4);
    step(1'b1);
    check_outs("e_pre", 2'd2, 4'b0100, 1'b1, 4'd2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_outs("e_async", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);
    check_outs("e_idle_zero", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    steps(16'b1000000, 7);
`ifdef SERDEMUX_PARITY_EN
    step(1'b0);
`endif
    check_outs("e_frame", 2'd0, 4'b0000, 1'b0, 4'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
